// File: rtl/cdr_os_core.sv
// Oversampling bang-bang CDR: proportional phase votes, saturating integrator
// feeding a drift accumulator, recovered-bit strobe and hysteretic lock flag.
module cdr_os_core #(
  parameter int OSR          = 8,
  parameter int ACC_W        = 8,
  parameter int DRIFT_W      = 12,
  parameter int LOCK_EDGES   = 16,
  parameter int UNLOCK_EDGES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    din,
  input  logic                    prop_en,
  input  logic                    int_en,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic                    locked,
  output logic [$clog2(OSR)-1:0]  phase,
  output logic [ACC_W-1:0]        integ
);

  localparam int PW = $clog2(OSR);
  localparam int GW = $clog2(LOCK_EDGES + 1);
  localparam int BW = $clog2(UNLOCK_EDGES + 1);

  localparam logic [PW-1:0] PH_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [PW-1:0] PH_TWO  = PW'(2);
  localparam logic [PW-1:0] PH_MID  = PW'(OSR / 2);
  localparam logic [PW-1:0] PH_LAST = PW'(OSR - 1);

  localparam logic [GW-1:0] GOOD_ZERO = {GW{1'b0}};
  localparam logic [GW-1:0] GOOD_ONE  = GW'(1);
  localparam logic [GW-1:0] LOCK_N    = GW'(LOCK_EDGES);
  localparam logic [BW-1:0] BAD_ZERO  = {BW{1'b0}};
  localparam logic [BW-1:0] BAD_ONE   = BW'(1);
  localparam logic [BW-1:0] UNLOCK_N  = BW'(UNLOCK_EDGES);

  localparam logic signed [1:0] V_ZERO = 2'sb00;
  localparam logic signed [1:0] V_ADV  = 2'sb01;
  localparam logic signed [1:0] V_RET  = 2'sb11;

  localparam logic signed [ACC_W-1:0] INT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] INT_MIN = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0]   SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   SUM_MIN = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};

  localparam logic signed [DRIFT_W:0] TH  = {3'b001, {(DRIFT_W-2){1'b0}}};
  localparam logic signed [DRIFT_W:0] NTH = {3'b111, {(DRIFT_W-2){1'b0}}};

  logic s1_q, s2_q, s3_q;
  logic [PW-1:0] ph_q, ph_d;
  logic signed [ACC_W-1:0] integ_q, integ_d;
  logic signed [DRIFT_W-1:0] drift_q, drift_d;
  logic signed [1:0] int_req_q, int_req_d;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic locked_q, locked_d;
  logic bit_out_q, bit_out_d;
  logic bit_valid_q, bit_valid_d;

  logic edge_s, edge_act_s, sample_s, good_pos_s;
  logic signed [1:0] vote_s, pv_s;
  logic signed [2:0] net_s;
  logic signed [ACC_W:0] integ_sum_s;
  logic signed [DRIFT_W:0] drift_sum_s, drift_hi_s, drift_lo_s;

  // Three-stage input synchronizer; runs regardless of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Votes, loop filter, phase slip, lock hysteresis and sampling.
  always_comb begin
    edge_s     = s2_q ^ s3_q;
    edge_act_s = ena & edge_s;
    sample_s   = ena & (ph_q == PH_MID);
    good_pos_s = (ph_q == PH_ZERO) | (ph_q == PH_ONE) | (ph_q == PH_LAST);

    if (!edge_act_s)           vote_s = V_ZERO;
    else if (ph_q == PH_ZERO)  vote_s = V_ZERO;
    else if (ph_q < PH_MID)    vote_s = V_RET;
    else                       vote_s = V_ADV;

    pv_s  = prop_en ? vote_s : V_ZERO;
    // Opposite proportional and integral requests cancel; same-sign ones clamp to one slip.
    net_s = {pv_s[1], pv_s} + {int_req_q[1], int_req_q};

    ph_d = ph_q;
    if (!ena)               ph_d = ph_q;
    else if (net_s > 3'sd0) ph_d = ph_q + PH_TWO;
    else if (net_s < 3'sd0) ph_d = ph_q;
    else                    ph_d = ph_q + PH_ONE;

    integ_sum_s = {integ_q[ACC_W-1], integ_q} + {{(ACC_W-1){vote_s[1]}}, vote_s};
    integ_d = integ_q;
    if (edge_act_s & int_en) begin
      if (integ_sum_s > SUM_MAX)      integ_d = INT_MAX;
      else if (integ_sum_s < SUM_MIN) integ_d = INT_MIN;
      else                            integ_d = ACC_W'(integ_sum_s);
    end else begin
      integ_d = integ_q;
    end

    drift_sum_s = {drift_q[DRIFT_W-1], drift_q}
                + {{(DRIFT_W+1-ACC_W){integ_q[ACC_W-1]}}, integ_q};
    drift_hi_s  = drift_sum_s - TH;
    drift_lo_s  = drift_sum_s + TH;
    drift_d   = drift_q;
    int_req_d = int_req_q;
    if (!ena) begin
      drift_d   = drift_q;
      int_req_d = int_req_q;
    end else if (!sample_s) begin
      drift_d   = drift_q;
      int_req_d = V_ZERO;
    end else if (drift_sum_s >= TH) begin
      drift_d   = DRIFT_W'(drift_hi_s);
      int_req_d = V_ADV;
    end else if (drift_sum_s <= NTH) begin
      drift_d   = DRIFT_W'(drift_lo_s);
      int_req_d = V_RET;
    end else begin
      drift_d   = DRIFT_W'(drift_sum_s);
      int_req_d = V_ZERO;
    end

    good_d   = good_q;
    bad_d    = bad_q;
    locked_d = locked_q;
    if (!edge_act_s) begin
      locked_d = locked_q;
    end else if (good_pos_s) begin
      bad_d = BAD_ZERO;
      if (good_q != LOCK_N) good_d = good_q + GOOD_ONE;
      else                  good_d = good_q;
      if (good_d == LOCK_N) locked_d = 1'b1;
      else                  locked_d = locked_q;
    end else begin
      good_d = GOOD_ZERO;
      if (bad_q != UNLOCK_N) bad_d = bad_q + BAD_ONE;
      else                   bad_d = bad_q;
      if (bad_d == UNLOCK_N) locked_d = 1'b0;
      else                   locked_d = locked_q;
    end

    bit_valid_d = sample_s;
    bit_out_d   = sample_s ? s2_q : bit_out_q;
  end

  // Core state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q        <= PH_ZERO;
      integ_q     <= {ACC_W{1'b0}};
      drift_q     <= {DRIFT_W{1'b0}};
      int_req_q   <= V_ZERO;
      good_q      <= GOOD_ZERO;
      bad_q       <= BAD_ZERO;
      locked_q    <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      ph_q        <= ph_d;
      integ_q     <= integ_d;
      drift_q     <= drift_d;
      int_req_q   <= int_req_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      locked_q    <= locked_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign locked    = locked_q;
  assign phase     = ph_q;
  assign integ     = integ_q;

endmodule
